// File: rtl/alu_issue_ctrl_pkg.sv
// Shared constants for the ALU issue controller: ALU function codes, opcodes, FSM states, flag layout.
package alu_issue_ctrl_pkg;

  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_SRL   = 6'b000010;
  localparam logic [5:0] FN_SRA   = 6'b000011;
  localparam logic [5:0] FN_SLLV  = 6'b000100;
  localparam logic [5:0] FN_ADDIU = 6'b000101;
  localparam logic [5:0] FN_SRLV  = 6'b000110;
  localparam logic [5:0] FN_SRAV  = 6'b000111;
  localparam logic [5:0] FN_ADDI  = 6'b001000;
  localparam logic [5:0] FN_SLTI  = 6'b001010;
  localparam logic [5:0] FN_SLTIU = 6'b001011;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_XOR   = 6'b100110;
  localparam logic [5:0] FN_NOR   = 6'b100111;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_SLTU  = 6'b101011;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DECODE,
    ST_EXEC,
    ST_WB
  } state_e;

  // Which flags an op may update: NZ only, +C, +C+V, +C+V with overflow trap.
  typedef enum logic [1:0] {
    CLS_NZ,
    CLS_NZC,
    CLS_NZCV,
    CLS_TRAP
  } op_cls_e;

  function automatic logic [31:0] sext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Instruction handshake, register-file read, ALU and writeback signals of the issue controller.
interface alu_issue_ctrl_if #(
  parameter int REG_AW = 5
);
  logic              instr_valid;
  logic              instr_ready;
  logic [31:0]       instr;
  logic [REG_AW-1:0] rs_addr;
  logic [REG_AW-1:0] rt_addr;
  logic [31:0]       rs_data;
  logic [31:0]       rt_data;
  logic [31:0]       alu_a;
  logic [31:0]       alu_b;
  logic [5:0]        alu_functn;
  logic [31:0]       alu_out;
  logic              alu_n;
  logic              alu_z;
  logic              alu_c;
  logic              alu_v;
  logic              wb_en;
  logic [REG_AW-1:0] wb_addr;
  logic [31:0]       wb_data;
  logic [3:0]        flags;
  logic              done;
  logic              illegal;
  logic              ovf_trap;

  modport master (
    input  instr_valid, instr, rs_data, rt_data, alu_out, alu_n, alu_z, alu_c, alu_v,
    output instr_ready, rs_addr, rt_addr, alu_a, alu_b, alu_functn,
           wb_en, wb_addr, wb_data, flags, done, illegal, ovf_trap
  );

  modport slave (
    output instr_valid, instr, rs_data, rt_data, alu_out, alu_n, alu_z, alu_c, alu_v,
    input  instr_ready, rs_addr, rt_addr, alu_a, alu_b, alu_functn,
           wb_en, wb_addr, wb_data, flags, done, illegal, ovf_trap
  );
endinterface

// File: rtl/alu_op_decode.sv
// Combinational MIPS decode: instruction + register data -> ALU function, operands, destination, flag class.
module alu_op_decode
  import alu_issue_ctrl_pkg::*;
(
  input  logic [31:0] instr_i,
  input  logic [31:0] rs_data_i,
  input  logic [31:0] rt_data_i,
  output logic [4:0]  rs_addr_o,
  output logic [4:0]  rt_addr_o,
  output logic [5:0]  functn_o,
  output logic [31:0] a_o,
  output logic [31:0] b_o,
  output logic [4:0]  dest_o,
  output op_cls_e     cls_o,
  output logic        legal_o
);

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic [15:0] imm;

  assign opcode    = instr_i[31:26];
  assign funct     = instr_i[5:0];
  assign shamt     = instr_i[10:6];
  assign imm       = instr_i[15:0];
  assign rs_addr_o = instr_i[25:21];
  assign rt_addr_o = instr_i[20:16];

  always_comb begin
    functn_o = FN_SLL;
    a_o      = rs_data_i;
    b_o      = rt_data_i;
    dest_o   = instr_i[20:16];
    cls_o    = CLS_NZ;
    legal_o  = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        dest_o = instr_i[15:11];
        case (funct)
          FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR,
          FN_XOR, FN_NOR, FN_SLT, FN_SLTU: begin
            legal_o  = 1'b1;
            functn_o = funct;
          end
          FN_SLL, FN_SRL, FN_SRA: begin
            legal_o  = 1'b1;
            functn_o = funct;
            a_o      = rt_data_i;
            b_o      = {27'b0, shamt};
          end
          FN_SLLV, FN_SRLV, FN_SRAV: begin
            legal_o  = 1'b1;
            functn_o = funct;
            a_o      = rt_data_i;
            b_o      = {27'b0, rs_data_i[4:0]};
          end
          default: legal_o = 1'b0;
        endcase
        if (funct == FN_ADD || funct == FN_SUB) cls_o = CLS_TRAP;
        else if (funct == FN_SUBU)              cls_o = CLS_NZCV;
        else if (funct == FN_ADDU)              cls_o = CLS_NZC;
      end
      OP_ADDI: begin
        legal_o  = 1'b1;
        functn_o = FN_ADDI;
        b_o      = sext16(imm);
        cls_o    = CLS_TRAP;
      end
      OP_ADDIU: begin
        legal_o  = 1'b1;
        functn_o = FN_ADDIU;
        b_o      = sext16(imm);
        cls_o    = CLS_NZC;
      end
      OP_SLTI, OP_SLTIU: begin
        legal_o  = 1'b1;
        functn_o = opcode;
        b_o      = sext16(imm);
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        legal_o  = 1'b1;
        functn_o = opcode;
        b_o      = {16'b0, imm};
      end
      // LUI is issued as a 16-bit left shift so the ALU's own LUI code is never needed.
      OP_LUI: begin
        legal_o  = 1'b1;
        functn_o = FN_SLL;
        a_o      = {16'b0, imm};
        b_o      = 32'd16;
      end
      default: legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Four-state issue controller (IDLE->DECODE->EXEC->WB) wrapping the ALU; one instruction at a time,
// instr_ready only in IDLE. Illegal encodings skip EXEC and retire with no writeback.
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int REG_AW      = 5,
  parameter bit TRAP_ON_OVF = 1'b1
) (
  input logic              clk,
  input logic              rst_n,
  alu_issue_ctrl_if.master bus
);

  state_e            state_q, state_d;
  logic [31:0]       instr_q, instr_d;
  logic [31:0]       alu_a_q, alu_a_d;
  logic [31:0]       alu_b_q, alu_b_d;
  logic [5:0]        functn_q, functn_d;
  logic [4:0]        dest_q, dest_d;
  op_cls_e           cls_q, cls_d;
  logic              wb_en_q, wb_en_d;
  logic [REG_AW-1:0] wb_addr_q, wb_addr_d;
  logic [31:0]       wb_data_q, wb_data_d;
  logic [3:0]        flags_q, flags_d;
  logic              done_q, done_d;
  logic              illegal_q, illegal_d;
  logic              trap_q, trap_d;
  logic              trap_hit;

  logic [4:0]  dec_rs_addr, dec_rt_addr, dec_dest;
  logic [5:0]  dec_functn;
  logic [31:0] dec_a, dec_b;
  op_cls_e     dec_cls;
  logic        dec_legal;

  alu_op_decode u_decode (
    .instr_i   (instr_q),
    .rs_data_i (bus.rs_data),
    .rt_data_i (bus.rt_data),
    .rs_addr_o (dec_rs_addr),
    .rt_addr_o (dec_rt_addr),
    .functn_o  (dec_functn),
    .a_o       (dec_a),
    .b_o       (dec_b),
    .dest_o    (dec_dest),
    .cls_o     (dec_cls),
    .legal_o   (dec_legal)
  );

  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    functn_d  = functn_q;
    dest_d    = dest_q;
    cls_d     = cls_q;
    flags_d   = flags_q;
    wb_en_d   = 1'b0;
    wb_addr_d = '0;
    wb_data_d = '0;
    done_d    = 1'b0;
    illegal_d = 1'b0;
    trap_d    = 1'b0;
    trap_hit  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.instr_valid) begin
          instr_d = bus.instr;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (dec_legal) begin
          alu_a_d  = dec_a;
          alu_b_d  = dec_b;
          functn_d = dec_functn;
          dest_d   = dec_dest;
          cls_d    = dec_cls;
          state_d  = ST_EXEC;
        end else begin
          done_d    = 1'b1;
          illegal_d = 1'b1;
          state_d   = ST_WB;
        end
      end
      ST_EXEC: begin
        trap_hit        = TRAP_ON_OVF && (cls_q == CLS_TRAP) && bus.alu_v;
        flags_d[FLAG_N] = bus.alu_n;
        flags_d[FLAG_Z] = bus.alu_z;
        if (cls_q != CLS_NZ)                         flags_d[FLAG_C] = bus.alu_c;
        if (cls_q == CLS_NZCV || cls_q == CLS_TRAP) flags_d[FLAG_V] = bus.alu_v;
        wb_en_d   = (dest_q != 5'd0) && !trap_hit;
        wb_addr_d = REG_AW'(dest_q);
        wb_data_d = bus.alu_out;
        done_d    = 1'b1;
        trap_d    = trap_hit;
        state_d   = ST_WB;
      end
      ST_WB:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      instr_q   <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      functn_q  <= '0;
      dest_q    <= '0;
      cls_q     <= CLS_NZ;
      wb_en_q   <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      flags_q   <= '0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      trap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      functn_q  <= functn_d;
      dest_q    <= dest_d;
      cls_q     <= cls_d;
      wb_en_q   <= wb_en_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
      flags_q   <= flags_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
      trap_q    <= trap_d;
    end
  end

  assign bus.instr_ready = (state_q == ST_IDLE);
  assign bus.rs_addr     = REG_AW'(dec_rs_addr);
  assign bus.rt_addr     = REG_AW'(dec_rt_addr);
  assign bus.alu_a       = alu_a_q;
  assign bus.alu_b       = alu_b_q;
  assign bus.alu_functn  = functn_q;
  assign bus.wb_en       = wb_en_q;
  assign bus.wb_addr     = wb_addr_q;
  assign bus.wb_data     = wb_data_q;
  assign bus.flags       = flags_q;
  assign bus.done        = done_q;
  assign bus.illegal     = illegal_q;
  assign bus.ovf_trap    = trap_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: two instances (trap on / trap off) driven in lockstep, checked against an
// instruction-level reference model; the ALU and register file are behavioural models in the bench.
module tb_alu_issue_ctrl;
  import alu_issue_ctrl_pkg::*;

  localparam longint MAXS = 64'sd2147483647;
  localparam longint MINS = -64'sd2147483648;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_issue_ctrl_if bus0 ();
  alu_issue_ctrl_if bus1 ();

  alu_issue_ctrl #(.REG_AW(5), .TRAP_ON_OVF(1'b1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  alu_issue_ctrl #(.REG_AW(5), .TRAP_ON_OVF(1'b0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  logic [31:0] rf0 [32];
  logic [31:0] rf1 [32];
  logic [3:0]  fl0, fl1;
  int          n_tests = 0;
  int          n_fail  = 0;

  logic        ob_wb_en0, ob_wb_en1, ob_ill0, ob_trap0, ob_trap1;
  logic [4:0]  ob_addr0;
  logic [31:0] ob_data0, ob_data1, ob_a, ob_b;
  logic [5:0]  ob_fn;
  logic [3:0]  ob_flags0;

  // Behavioural ALU: {n,z,c,v,out}
  function automatic logic [35:0] alu_model(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    logic [31:0] o;
    logic        c, v;
    s = '0; o = '0; c = 1'b0; v = 1'b0;
    case (fn)
      6'b100000, 6'b100001, 6'b001000, 6'b000101: begin
        s = {1'b0, a} + {1'b0, b};
        o = s[31:0]; c = s[32];
        v = (a[31] == b[31]) && (o[31] != a[31]);
      end
      6'b100010, 6'b100011: begin
        s = {1'b0, a} + {1'b0, ~b} + 33'd1;
        o = s[31:0]; c = s[32];
        v = (a[31] != b[31]) && (o[31] != a[31]);
      end
      6'b100100, 6'b001100: o = a & b;
      6'b100101, 6'b001101: o = a | b;
      6'b100110, 6'b001110: o = a ^ b;
      6'b100111:            o = ~(a | b);
      6'b101010, 6'b001010: o = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6'b101011, 6'b001011: o = (a < b) ? 32'd1 : 32'd0;
      6'b000000, 6'b000100: o = a << b[4:0];
      6'b000010, 6'b000110: o = a >> b[4:0];
      6'b000011, 6'b000111: o = $signed(a) >>> b[4:0];
      default:              o = 32'hDEAD_BEEF;
    endcase
    return {o[31], (o == 32'd0), c, v, o};
  endfunction

  assign {bus0.alu_n, bus0.alu_z, bus0.alu_c, bus0.alu_v, bus0.alu_out} = alu_model(bus0.alu_functn, bus0.alu_a, bus0.alu_b);
  assign {bus1.alu_n, bus1.alu_z, bus1.alu_c, bus1.alu_v, bus1.alu_out} = alu_model(bus1.alu_functn, bus1.alu_a, bus1.alu_b);
  assign bus0.rs_data = rf0[bus0.rs_addr];
  assign bus0.rt_data = rf0[bus0.rt_addr];
  assign bus1.rs_data = rf1[bus1.rs_addr];
  assign bus1.rt_data = rf1[bus1.rt_addr];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Instruction-level reference: architectural result, destination, flag update and trap decision.
  task automatic model_exec(input logic [31:0] ins, input logic [31:0] rsv, input logic [31:0] rtv,
                            input bit trap_en, inout logic [3:0] flg, output bit legal, output bit wb,
                            output logic [4:0] dst, output logic [31:0] res, output bit trapped);
    logic [5:0]  op, fn;
    logic [31:0] simm, zimm, b;
    bit          arith, sub, upd_v, may_trap, c, v;
    longint      sr;
    op = ins[31:26]; fn = ins[5:0];
    simm = {{16{ins[15]}}, ins[15:0]};
    zimm = {16'h0, ins[15:0]};
    legal = 1'b1; arith = 1'b0; sub = 1'b0; upd_v = 1'b0; may_trap = 1'b0;
    c = 1'b0; v = 1'b0; res = '0; b = rtv; dst = ins[15:11];
    if (op == 6'h00) begin
      case (fn)
        6'h20: begin arith = 1; upd_v = 1; may_trap = 1; end
        6'h21: arith = 1;
        6'h22: begin arith = 1; sub = 1; upd_v = 1; may_trap = 1; end
        6'h23: begin arith = 1; sub = 1; upd_v = 1; end
        6'h24: res = rsv & rtv;
        6'h25: res = rsv | rtv;
        6'h26: res = rsv ^ rtv;
        6'h27: res = ~(rsv | rtv);
        6'h2A: res = ($signed(rsv) < $signed(rtv)) ? 32'd1 : 32'd0;
        6'h2B: res = (rsv < rtv) ? 32'd1 : 32'd0;
        6'h00: res = rtv << ins[10:6];
        6'h02: res = rtv >> ins[10:6];
        6'h03: res = $signed(rtv) >>> ins[10:6];
        6'h04: res = rtv << rsv[4:0];
        6'h06: res = rtv >> rsv[4:0];
        6'h07: res = $signed(rtv) >>> rsv[4:0];
        default: legal = 1'b0;
      endcase
    end else begin
      dst = ins[20:16];
      case (op)
        6'h08: begin arith = 1; b = simm; upd_v = 1; may_trap = 1; end
        6'h09: begin arith = 1; b = simm; end
        6'h0A: res = ($signed(rsv) < $signed(simm)) ? 32'd1 : 32'd0;
        6'h0B: res = (rsv < simm) ? 32'd1 : 32'd0;
        6'h0C: res = rsv & zimm;
        6'h0D: res = rsv | zimm;
        6'h0E: res = rsv ^ zimm;
        6'h0F: res = {ins[15:0], 16'h0};
        default: legal = 1'b0;
      endcase
    end
    if (arith) begin
      res = sub ? rsv - b : rsv + b;
      c   = sub ? (rsv >= b) : (res < rsv);
      sr  = sub ? (longint'($signed(rsv)) - longint'($signed(b))) : (longint'($signed(rsv)) + longint'($signed(b)));
      v   = (sr > MAXS) || (sr < MINS);
    end
    if (legal) begin
      flg[3] = res[31];
      flg[2] = (res == 32'd0);
      if (arith) flg[1] = c;
      if (upd_v) flg[0] = v;
    end
    trapped = legal && trap_en && may_trap && v;
    wb      = legal && (dst != 5'd0) && !trapped;
  endtask

  task automatic set_reg(input int r, input logic [31:0] v);
    rf0[r] = v;
    rf1[r] = v;
  endtask

  task automatic issue(input logic [31:0] ins, input bit junk);
    bit          leg0, wb0, tr0, leg1, wb1, tr1, seen;
    logic [4:0]  d0, d1;
    logic [31:0] r0, r1;
    int          n;
    model_exec(ins, rf0[ins[25:21]], rf0[ins[20:16]], 1'b1, fl0, leg0, wb0, d0, r0, tr0);
    model_exec(ins, rf1[ins[25:21]], rf1[ins[20:16]], 1'b0, fl1, leg1, wb1, d1, r1, tr1);
    @(negedge clk);
    check_val("ready_idle", bus0.instr_ready, 1);
    bus0.instr_valid = 1'b1; bus0.instr = ins;
    bus1.instr_valid = 1'b1; bus1.instr = ins;
    @(posedge clk);
    #1;
    bus0.instr_valid = 1'b0; bus0.instr = $urandom;
    bus1.instr_valid = 1'b0; bus1.instr = $urandom;
    n = 0; seen = 1'b0;
    while (!seen && n < 8) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        check_val("ready_busy", bus0.instr_ready, 0);
        if (junk) begin
          bus0.instr_valid = 1'b1; bus0.instr = $urandom;
          bus1.instr_valid = 1'b1; bus1.instr = $urandom;
        end
      end
      if (n == 2) begin
        bus0.instr_valid = 1'b0; bus1.instr_valid = 1'b0;
        ob_a = bus0.alu_a; ob_b = bus0.alu_b; ob_fn = bus0.alu_functn;
      end
      if (bus0.done) seen = 1'b1;
    end
    check_val("latency", n, leg0 ? 3 : 2);
    check_val("done1", bus1.done, 1);
    check_val("wb_en0", bus0.wb_en, wb0);
    check_val("wb_en1", bus1.wb_en, wb1);
    check_val("illegal0", bus0.illegal, !leg0);
    check_val("illegal1", bus1.illegal, !leg1);
    check_val("ovf_trap0", bus0.ovf_trap, tr0);
    check_val("ovf_trap1", bus1.ovf_trap, tr1);
    check_val("flags0", bus0.flags, fl0);
    check_val("flags1", bus1.flags, fl1);
    if (wb0) begin
      check_val("wb_addr0", bus0.wb_addr, d0);
      check_val("wb_data0", bus0.wb_data, r0);
    end
    if (wb1) begin
      check_val("wb_addr1", bus1.wb_addr, d1);
      check_val("wb_data1", bus1.wb_data, r1);
    end
    ob_wb_en0 = bus0.wb_en; ob_wb_en1 = bus1.wb_en; ob_ill0 = bus0.illegal;
    ob_trap0 = bus0.ovf_trap; ob_trap1 = bus1.ovf_trap; ob_addr0 = bus0.wb_addr;
    ob_data0 = bus0.wb_data; ob_data1 = bus1.wb_data; ob_flags0 = bus0.flags;
    if (wb0) rf0[d0] = r0;
    if (wb1) rf1[d1] = r1;
    @(negedge clk);
    check_val("done_pulse", bus0.done, 0);
    check_val("wb_pulse", bus0.wb_en, 0);
    check_val("ready_back", bus0.instr_ready, 1);
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  logic [5:0] rfun [16] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                            6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07};
  logic [31:0] bad [3] = '{32'h0022_0019, 32'h8C22_0000, 32'hFC00_0000};

  initial begin
    logic [31:0] ins;
    logic [4:0]  rs, rt, rd;
    rst_n = 1'b0;
    bus0.instr_valid = 1'b0; bus0.instr = '0;
    bus1.instr_valid = 1'b0; bus1.instr = '0;
    for (int i = 0; i < 32; i++) set_reg(i, 32'h0);
    fl0 = 4'h0; fl1 = 4'h0;
    repeat (3) @(negedge clk);
    check_val("rst_ready", bus0.instr_ready, 1);
    check_val("rst_done", bus0.done, 0);
    check_val("rst_wb_en", bus0.wb_en, 0);
    check_val("rst_flags", bus0.flags, 0);
    check_val("rst_functn", bus0.alu_functn, 0);
    check_val("rst_alu_a", bus0.alu_a, 0);
    check_val("rst_trap", bus0.ovf_trap, 0);
    rst_n = 1'b1;

    set_reg(1, 32'd5);
    issue(32'h2022_FFFF, 1'b0);
    check_val("addi_wb_en", ob_wb_en0, 1);
    check_val("addi_addr", ob_addr0, 2);
    check_val("addi_data", ob_data0, 4);
    check_val("addi_flags", ob_flags0, 4'b0010);

    set_reg(1, 32'h7FFF_FFFF); set_reg(2, 32'd1);
    issue(32'h0022_1820, 1'b0);
    check_val("add_trap", ob_trap0, 1);
    check_val("add_wb_en", ob_wb_en0, 0);
    check_val("add_flags", ob_flags0, 4'b1001);
    check_val("add_notrap_wb", ob_wb_en1, 1);
    check_val("add_notrap_data", ob_data1, 32'h8000_0000);
    check_val("add_notrap_trap", ob_trap1, 0);

    issue(32'h3C04_1234, 1'b0);
    check_val("lui_functn", ob_fn, 0);
    check_val("lui_b", ob_b, 16);
    check_val("lui_addr", ob_addr0, 4);
    check_val("lui_data", ob_data0, 32'h1234_0000);
    check_val("lui_flags", ob_flags0, 4'b0001);

    set_reg(2, 32'hF);
    issue(32'h0002_2900, 1'b0);
    check_val("sll_a", ob_a, 32'hF);
    check_val("sll_b", ob_b, 4);
    check_val("sll_addr", ob_addr0, 5);
    check_val("sll_data", ob_data0, 32'hF0);

    issue(32'hFC00_0000, 1'b0);
    check_val("ill_op", ob_ill0, 1);
    check_val("ill_flags", ob_flags0, 4'b0001);
    issue(32'h0022_0019, 1'b0);
    check_val("multu_ill", ob_ill0, 1);
    check_val("multu_wb", ob_wb_en0, 0);
    issue(32'h3400_ABCD, 1'b0);
    check_val("ori_r0_ill", ob_ill0, 0);
    check_val("ori_r0_wb", ob_wb_en0, 0);

    for (int i = 1; i < 8; i++) set_reg(i, pick_val());
    for (int t = 0; t < 60; t++) begin
      if ($urandom_range(0, 2) == 0) set_reg($urandom_range(1, 7), pick_val());
      rs = 5'($urandom_range(0, 7)); rt = 5'($urandom_range(0, 7)); rd = 5'($urandom_range(0, 7));
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: ins = {6'h00, rs, rt, rd, 5'($urandom_range(0, 31)), rfun[$urandom_range(0, 15)]};
        5, 6, 7, 8:    ins = {6'($urandom_range(8, 15)), rs, rt, 16'($urandom)};
        default:       ins = bad[$urandom_range(0, 2)];
      endcase
      issue(ins, ($urandom_range(0, 1) == 1));
    end

    // Reset while an instruction sits in EXEC.
    set_reg(1, 32'h1); set_reg(2, 32'h2);
    @(negedge clk);
    bus0.instr_valid = 1'b1; bus0.instr = 32'h0022_1820;
    bus1.instr_valid = 1'b1; bus1.instr = 32'h0022_1820;
    @(posedge clk);
    #1;
    bus0.instr_valid = 1'b0; bus1.instr_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_val("arst_ready", bus0.instr_ready, 1);
    check_val("arst_done", bus0.done, 0);
    check_val("arst_wb_en", bus0.wb_en, 0);
    check_val("arst_flags", bus0.flags, 0);
    @(negedge clk);
    check_val("arst_done_hold", bus0.done, 0);
    check_val("arst_wb_hold", bus0.wb_en, 0);
    check_val("arst_flags1", bus1.flags, 0);
    rst_n = 1'b1;
    fl0 = 4'h0; fl1 = 4'h0;
    issue(32'h2022_FFFF, 1'b0);
    check_val("post_rst_wb", ob_wb_en0, 1);
    check_val("post_rst_data", ob_data0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
